// File: rtl/ps2_voice_pkg.sv
// Shared constants for the PS/2 voice allocator: scancodes, note geometry and
// the scancode-prefix FSM state type.
package ps2_voice_pkg;

    localparam int NUM_NOTES = 18;
    localparam int NOTE_W    = 5;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Note keys in ascending pitch order: A W S E D F T G Y H U J K O L P ; '
    localparam logic [7:0] SC_NOTE_0  = 8'h1C;
    localparam logic [7:0] SC_NOTE_1  = 8'h1D;
    localparam logic [7:0] SC_NOTE_2  = 8'h1B;
    localparam logic [7:0] SC_NOTE_3  = 8'h24;
    localparam logic [7:0] SC_NOTE_4  = 8'h23;
    localparam logic [7:0] SC_NOTE_5  = 8'h2B;
    localparam logic [7:0] SC_NOTE_6  = 8'h2C;
    localparam logic [7:0] SC_NOTE_7  = 8'h34;
    localparam logic [7:0] SC_NOTE_8  = 8'h35;
    localparam logic [7:0] SC_NOTE_9  = 8'h33;
    localparam logic [7:0] SC_NOTE_10 = 8'h3C;
    localparam logic [7:0] SC_NOTE_11 = 8'h3B;
    localparam logic [7:0] SC_NOTE_12 = 8'h42;
    localparam logic [7:0] SC_NOTE_13 = 8'h44;
    localparam logic [7:0] SC_NOTE_14 = 8'h4B;
    localparam logic [7:0] SC_NOTE_15 = 8'h4D;
    localparam logic [7:0] SC_NOTE_16 = 8'h4C;
    localparam logic [7:0] SC_NOTE_17 = 8'h52;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

endpackage

// File: rtl/ps2_note_decode.sv
// Maps a PS/2 scancode byte to a note index; non-note bytes report is_note=0.
module ps2_note_decode
    import ps2_voice_pkg::*;
(
    input  logic [7:0]        code,
    output logic              is_note,
    output logic [NOTE_W-1:0] note_idx
);

    always_comb begin
        is_note  = 1'b1;
        note_idx = '0;
        case (code)
            SC_NOTE_0:  note_idx = 5'd0;
            SC_NOTE_1:  note_idx = 5'd1;
            SC_NOTE_2:  note_idx = 5'd2;
            SC_NOTE_3:  note_idx = 5'd3;
            SC_NOTE_4:  note_idx = 5'd4;
            SC_NOTE_5:  note_idx = 5'd5;
            SC_NOTE_6:  note_idx = 5'd6;
            SC_NOTE_7:  note_idx = 5'd7;
            SC_NOTE_8:  note_idx = 5'd8;
            SC_NOTE_9:  note_idx = 5'd9;
            SC_NOTE_10: note_idx = 5'd10;
            SC_NOTE_11: note_idx = 5'd11;
            SC_NOTE_12: note_idx = 5'd12;
            SC_NOTE_13: note_idx = 5'd13;
            SC_NOTE_14: note_idx = 5'd14;
            SC_NOTE_15: note_idx = 5'd15;
            SC_NOTE_16: note_idx = 5'd16;
            SC_NOTE_17: note_idx = 5'd17;
            default:    is_note  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_voice_allocator.sv
// Turns the PS/2 scancode stream into held-key state and a polyphonic voice
// pool, stealing voices round-robin once every voice is busy.
module ps2_voice_allocator
    import ps2_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         all_off,
    output logic [NUM_NOTES-1:0]         key_held,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic                         note_on,
    output logic                         note_off,
    output logic [VIDX_W-1:0]            event_voice,
    output logic [7:0]                   last_code
);

    ps2_state_t          state;
    logic [VIDX_W-1:0]   steal_ptr;

    logic                is_note;
    logic [NOTE_W-1:0]   note_idx;

    logic                free_found;
    logic [VIDX_W-1:0]   free_idx;
    logic [NUM_VOICES-1:0] free_sel;
    logic                match_found;
    logic [VIDX_W-1:0]   match_idx;
    logic [NUM_VOICES-1:0] match_sel;
    logic [NUM_VOICES-1:0] steal_sel;
    logic [NUM_VOICES-1:0] alloc_sel;
    logic [VIDX_W-1:0]   alloc_idx;
    logic                accept;
    logic                do_make;
    logic                do_break;

    ps2_note_decode u_decode (
        .code     (rx_data),
        .is_note  (is_note),
        .note_idx (note_idx)
    );

    // Lowest free voice, lowest active voice sounding this note, and the steal victim.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        free_sel    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        match_sel   = '0;
        steal_sel   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!free_found && !voice_active[v]) begin
                free_found  = 1'b1;
                free_idx    = VIDX_W'(v);
                free_sel[v] = 1'b1;
            end
            if (!match_found && voice_active[v] &&
                (voice_note[v*NOTE_W +: NOTE_W] == note_idx)) begin
                match_found  = 1'b1;
                match_idx    = VIDX_W'(v);
                match_sel[v] = 1'b1;
            end
            steal_sel[v] = (VIDX_W'(v) == steal_ptr);
        end
    end

    assign alloc_sel = free_found ? free_sel : steal_sel;
    assign alloc_idx = free_found ? free_idx : steal_ptr;

    // A held key's repeat make and a release of an unheld key both do nothing.
    assign accept   = rx_valid && !all_off;
    assign do_make  = accept && is_note && (state == ST_IDLE) && !key_held[note_idx];
    assign do_break = accept && is_note && (state == ST_BRK)  &&  key_held[note_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            steal_ptr    <= '0;
            key_held     <= '0;
            voice_active <= '0;
            voice_note   <= '0;
            note_on      <= 1'b0;
            note_off     <= 1'b0;
            event_voice  <= '0;
            last_code    <= '0;
        end else begin
            note_on  <= 1'b0;
            note_off <= 1'b0;

            if (rx_valid) begin
                last_code <= rx_data;
            end

            if (all_off) begin
                state        <= ST_IDLE;
                steal_ptr    <= '0;
                key_held     <= '0;
                voice_active <= '0;
                voice_note   <= '0;
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SC_BREAK)    state <= ST_BRK;
                        else if (rx_data == SC_EXT) state <= ST_EXT;
                    end
                    ST_BRK: begin
                        if (is_note)                state <= ST_IDLE;
                        else if (rx_data == SC_EXT) state <= ST_EXT;
                        else if (rx_data != SC_BREAK) state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        state <= (rx_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (do_make) begin
                key_held[note_idx] <= 1'b1;
                note_on            <= 1'b1;
                event_voice        <= alloc_idx;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (alloc_sel[v]) begin
                        voice_active[v]                 <= 1'b1;
                        voice_note[v*NOTE_W +: NOTE_W]  <= note_idx;
                    end
                end
                if (!free_found) begin
                    steal_ptr <= (steal_ptr == VIDX_W'(NUM_VOICES - 1)) ?
                                 '0 : steal_ptr + VIDX_W'(1);
                end
            end

            // A stolen note has no voice left to release, so it pulses nothing.
            if (do_break) begin
                key_held[note_idx] <= 1'b0;
                if (match_found) begin
                    note_off    <= 1'b1;
                    event_voice <= match_idx;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (match_sel[v]) voice_active[v] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
